// File: rtl/ritc_align_sequencer.sv
// Power-up word aligner for the 72 RITC data bits: drives the datapath register bus,
// reads DPTRAINING back per bit and bitslips until the training pattern is seen.
module ritc_align_sequencer #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hA5,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_SLIP      = 4,
  parameter int unsigned MATCH_COUNT   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [71:0] fail_mask_o,
  output logic        user_sel_o,
  output logic        user_wr_o,
  output logic [3:0]  user_addr_o,
  output logic [31:0] user_dat_o,
  input  logic [31:0] user_dat_i
);

  localparam int unsigned TMR_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SLIP_W  = (MAX_SLIP > 0) ? $clog2(MAX_SLIP + 1) : 1;
  localparam int unsigned MATCH_W = (MATCH_COUNT > 0) ? $clog2(MATCH_COUNT + 1) : 1;
  localparam int unsigned NBITS   = 72;
  localparam logic [3:0]  BUS_ADDR = 4'd2;
  localparam logic [3:0]  LAST_BIT = 4'd11;
  localparam logic [2:0]  LAST_CH  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_SETTLE, ST_READ, ST_CHECK, ST_SLIP, ST_NEXT, ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [3:0]          bit_q, bit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SLIP_W-1:0]   slip_q, slip_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic                rd_ph_q, rd_ph_d;
  logic [7:0]          sample_q, sample_d;
  logic [NBITS-1:0]    mask_q, mask_d;
  logic                busy_d, done_d, fail_d, sel_d, wr_d;
  logic [3:0]          addr_d;
  logic [31:0]         dat_d;
  logic [6:0]          bit_idx;
  logic                dat_hi_unused;

  // Only the low byte of DPTRAINING carries the training pattern
  assign dat_hi_unused = ^user_dat_i[31:8];
  assign bit_idx       = 7'(ch_q) * 7'd12 + 7'(bit_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      bit_q       <= '0;
      timer_q     <= '0;
      slip_q      <= '0;
      match_q     <= '0;
      rd_ph_q     <= 1'b0;
      sample_q    <= '0;
      mask_q      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      user_sel_o  <= 1'b0;
      user_wr_o   <= 1'b0;
      user_addr_o <= '0;
      user_dat_o  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      timer_q     <= timer_d;
      slip_q      <= slip_d;
      match_q     <= match_d;
      rd_ph_q     <= rd_ph_d;
      sample_q    <= sample_d;
      mask_q      <= mask_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      fail_o      <= fail_d;
      user_sel_o  <= sel_d;
      user_wr_o   <= wr_d;
      user_addr_o <= addr_d;
      user_dat_o  <= dat_d;
    end
  end

  assign fail_mask_o = mask_q;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    bit_d    = bit_q;
    timer_d  = timer_q;
    slip_d   = slip_q;
    match_d  = match_q;
    rd_ph_d  = rd_ph_q;
    sample_d = sample_q;
    mask_d   = mask_q;
    busy_d   = busy_o;
    fail_d   = fail_o;
    done_d   = 1'b0;
    sel_d    = 1'b0;
    wr_d     = 1'b0;
    dat_d    = '0;
    addr_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ch_d    = '0;
          bit_d   = '0;
          slip_d  = '0;
          match_d = '0;
          mask_d  = '0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        timer_d = TMR_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          rd_ph_d = 1'b0;
          state_d = ST_READ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_READ: begin
        // Bus data is sampled on the edge that ends the second read cycle
        if (rd_ph_q) begin
          sample_d = user_dat_i[7:0];
          rd_ph_d  = 1'b0;
          state_d  = ST_CHECK;
        end else begin
          rd_ph_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (sample_q == TRAIN_PATTERN) begin
          match_d = match_q + 1'b1;
          if (match_d == MATCH_W'(MATCH_COUNT)) begin
            state_d = ST_NEXT;
          end else begin
            timer_d = TMR_W'(SETTLE_CYCLES - 1);
            state_d = ST_SETTLE;
          end
        end else begin
          match_d = '0;
          if (slip_q == SLIP_W'(MAX_SLIP)) begin
            mask_d[bit_idx] = 1'b1;
            state_d         = ST_NEXT;
          end else begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        slip_d  = slip_q + 1'b1;
        timer_d = TMR_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_NEXT: begin
        slip_d  = '0;
        match_d = '0;
        if (bit_q != LAST_BIT) begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_SELECT;
        end else if (ch_q != LAST_CH) begin
          bit_d   = '0;
          ch_d    = ch_q + 1'b1;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are registered against the state being entered
    case (state_d)
      ST_SELECT: begin
        sel_d = 1'b1;
        wr_d  = 1'b1;
        dat_d = {9'd0, ch_d, bit_d, 16'd0};
      end
      ST_READ: sel_d = 1'b1;
      ST_SLIP: begin
        sel_d = 1'b1;
        wr_d  = 1'b1;
        dat_d = {2'b01, 7'd0, ch_d, bit_d, 16'd0};
      end
      ST_FINISH: begin
        sel_d  = 1'b1;
        wr_d   = 1'b1;
        dat_d  = 32'h8000_0000;
        done_d = 1'b1;
        fail_d = |mask_d;
      end
      default: ;
    endcase

    addr_d = busy_d ? BUS_ADDR : 4'd0;
  end

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Randomized bench for ritc_align_sequencer: scripted DPTRAINING responses per bit,
// expected bus write stream and fail mask derived from the alignment rules.
module tb_ritc_align_sequencer;

  localparam int unsigned SETTLE = 5;
  localparam logic [7:0]  PAT    = 8'hA5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        busy_o, done_o, fail_o;
  logic [71:0] fail_mask_o;
  logic        user_sel_o, user_wr_o;
  logic [3:0]  user_addr_o;
  logic [31:0] user_dat_o;
  logic [31:0] user_dat_i;

  ritc_align_sequencer #(
    .TRAIN_PATTERN(PAT),
    .SETTLE_CYCLES(SETTLE),
    .MAX_SLIP(4),
    .MATCH_COUNT(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .fail_o(fail_o),
    .fail_mask_o(fail_mask_o),
    .user_sel_o(user_sel_o),
    .user_wr_o(user_wr_o),
    .user_addr_o(user_addr_o),
    .user_dat_o(user_dat_o),
    .user_dat_i(user_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Per-bit read script: k-th read on a bit returns a matching word iff match_seq[i][k]
  logic        match_seq [72][16];
  logic [31:0] rd_word   [72][16];
  logic [31:0] exp_wr [$];
  logic [71:0] exp_mask;
  int          scen;

  int tests = 0;
  int fails = 0;

  // Bus slave: tracks the selected bit and how many reads it has served
  logic [6:0] cur_sel;
  int         rd_idx;
  logic       rd_ph;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_sel <= '0;
      rd_idx  <= 0;
      rd_ph   <= 1'b0;
    end else if (user_sel_o && user_wr_o) begin
      rd_ph <= 1'b0;
      if (user_dat_o[31:30] == 2'b00) begin
        cur_sel <= user_dat_o[22:16];
        rd_idx  <= 0;
      end
    end else if (user_sel_o) begin
      if (rd_ph) begin
        rd_idx <= rd_idx + 1;
        rd_ph  <= 1'b0;
      end else begin
        rd_ph <= 1'b1;
      end
    end else begin
      rd_ph <= 1'b0;
    end
  end

  function automatic logic [31:0] bus_word(input logic [6:0] s, input int k);
    int i;
    if (s[3:0] > 4'd11 || s[6:4] > 3'd5 || k > 15) return 32'h0;
    i = int'(s[6:4]) * 12 + int'(s[3:0]);
    return rd_word[i][k];
  endfunction

  always_comb user_dat_i = (user_addr_o == 4'd2) ? bus_word(cur_sel, rd_idx) : 32'h0;

  // mode 0: always aligned; 1: directed cases; 2: random
  task automatic gen(input int mode);
    logic [7:0] mis;
    logic       m;
    logic       dead;
    for (int i = 0; i < 72; i++) begin
      dead = (mode == 2) && ($urandom_range(0, 99) < 6);
      for (int k = 0; k < 16; k++) begin
        if (mode == 2) m = !dead && ($urandom_range(0, 99) < 65);
        else           m = 1'b1;
        if (mode == 1) begin
          if (i == 29) m = (k >= 3);
          if (i == 59) m = 1'b0;
          if (i == 0)  m = (k != 1);
        end
        mis = 8'($urandom);
        if (mis == PAT) mis = mis ^ 8'h01;
        match_seq[i][k] = m;
        rd_word[i][k]   = m ? {24'($urandom), PAT} : {24'($urandom), mis};
      end
    end
  endtask

  // Reference: walk each bit's read script with the match/slip rules
  task automatic build_expect();
    int i, m, sl;
    logic [31:0] s;
    exp_wr.delete();
    exp_mask = '0;
    for (int ch = 0; ch < 6; ch++) begin
      for (int b = 0; b < 12; b++) begin
        i = ch * 12 + b;
        s = 32'(ch * 16 + b) << 16;
        exp_wr.push_back(s);
        m  = 0;
        sl = 0;
        for (int k = 0; k < 16; k++) begin
          if (match_seq[i][k]) begin
            m++;
            if (m == 2) break;
          end else begin
            m = 0;
            if (sl == 4) begin
              exp_mask[i] = 1'b1;
              break;
            end
            sl++;
            exp_wr.push_back(32'h4000_0000 | s);
          end
        end
      end
    end
    exp_wr.push_back(32'h8000_0000);
  endtask

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Compare process, sampled on the falling edge
  int          ptr, n_sel, n_slip, n_slip25, n_slip4b, n_done, rd_len, gap;
  logic        last_wr, prev_busy, prev_done, mask_valid;
  logic [71:0] held_mask;

  initial begin
    ptr = 0; n_sel = 0; n_slip = 0; n_slip25 = 0; n_slip4b = 0; n_done = 0;
    rd_len = 0; gap = 0; last_wr = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    mask_valid = 1'b0; held_mask = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        chk("reset_ctl", 72'({busy_o, done_o, fail_o, user_sel_o, user_wr_o, user_addr_o}), 72'd0);
        chk("reset_mask", fail_mask_o, 72'd0);
        chk("reset_dat", 72'(user_dat_o), 72'd0);
        mask_valid = 1'b0;
        prev_busy  = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (busy_o && !prev_busy) begin
          ptr = 0; n_sel = 0; n_slip = 0; n_slip25 = 0; n_slip4b = 0; n_done = 0;
          rd_len = 0; gap = 0; last_wr = 1'b0; mask_valid = 1'b0;
          chk("start_clears_fail", 72'({fail_o, fail_mask_o}), 72'd0);
        end
        chk("addr", 72'(user_addr_o), busy_o ? 72'd2 : 72'd0);
        if (user_wr_o) begin
          chk("wr_qualified", 72'(user_sel_o), 72'd1);
          if (ptr < exp_wr.size()) chk("wr_dat", 72'(user_dat_o), 72'(exp_wr[ptr]));
          else                     chk("wr_overrun", 72'(ptr), 72'(exp_wr.size() - 1));
          ptr++;
          if (user_dat_o[31:30] == 2'b00) n_sel++;
          if (user_dat_o[30]) n_slip++;
          if (user_dat_o == 32'h4025_0000) n_slip25++;
          if (user_dat_o == 32'h404B_0000) n_slip4b++;
        end
        if (busy_o) begin
          if (user_sel_o && !user_wr_o) begin
            if (rd_len == 0) chk("settle_gap", 72'(gap), last_wr ? 72'(SETTLE) : 72'(SETTLE + 1));
            rd_len++;
          end else begin
            if (rd_len != 0) begin
              chk("read_len", 72'(rd_len), 72'd2);
              rd_len  = 0;
              last_wr = 1'b0;
              gap     = 0;
            end
            if (user_wr_o) begin
              last_wr = 1'b1;
              gap     = 0;
            end else begin
              gap++;
            end
          end
        end
        if (prev_done) chk("busy_drops", 72'(busy_o), 72'd0);
        if (done_o) begin
          n_done++;
          chk("done_once", 72'(n_done), 72'd1);
          chk("done_busy", 72'(busy_o), 72'd1);
          chk("done_dat", 72'(user_dat_o), 72'h8000_0000);
          chk("done_all_writes", 72'(ptr), 72'(exp_wr.size()));
          chk("fail_mask", fail_mask_o, exp_mask);
          chk("fail_o", 72'(fail_o), 72'(|exp_mask));
          if (scen == 1) begin
            chk("s1_sel_writes", 72'(n_sel), 72'd72);
            chk("s1_slips", 72'(n_slip), 72'd0);
            chk("s1_mask", fail_mask_o, 72'd0);
          end
          if (scen == 2) begin
            chk("s2_sel_writes", 72'(n_sel), 72'd72);
            chk("s2_slip25", 72'(n_slip25), 72'd3);
            chk("s2_slip4b", 72'(n_slip4b), 72'd4);
            chk("s2_slips_total", 72'(n_slip), 72'd8);
            chk("s2_mask", fail_mask_o, 72'h0800_0000_0000_0000);
            chk("s2_fail_o", 72'(fail_o), 72'd1);
          end
          mask_valid = 1'b1;
          held_mask  = exp_mask;
        end else if (!busy_o && mask_valid) begin
          chk("idle_hold", 72'({fail_o, fail_mask_o}), 72'({|held_mask, held_mask}));
        end
        prev_busy = busy_o;
        prev_done = done_o;
      end
    end
  end

  task automatic kick(input int mode, input int sc);
    gen(mode);
    build_expect();
    scen = sc;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 20000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!done_o) begin
      $display("FAIL done_timeout: no done_o after %0d cycles", n);
      $fatal(1, "timeout");
    end
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    rst_i   = 1'b1;
    start_i = 1'b0;
    scen    = 0;
    gen(0);
    build_expect();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);

    kick(0, 1); wait_done();
    kick(1, 2); wait_done();
    kick(2, 0); wait_done();
    kick(2, 0); wait_done();

    // Reset in the settle window after selecting a ch3 bit
    kick(2, 0);
    n = 0;
    while (!(user_wr_o && user_dat_o[31:30] == 2'b00 && user_dat_o[22:20] == 3'd3) && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20000) begin
      $display("FAIL reach_ch3: no ch3 select after %0d cycles", n);
      $fatal(1, "timeout");
    end
    @(posedge clk_i); #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    kick(2, 0); wait_done();

    // start_i pulses mid-pass must not restart the sequence
    kick(2, 0);
    for (int p = 0; p < 4; p++) begin
      repeat (150 + $urandom_range(0, 100)) @(posedge clk_i);
      #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
    end
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
